// File: rtl/hazard_scoreboard.sv
// Purpose: decode-stage hazard detection and operand forwarding selects for the in-order pipeline.
// Latency: stall/issue are combinational; fwd_*_sel and inflight are registered (valid the cycle after issue).
// Backpressure: hazard inserts a bubble while decode holds; ext_stall freezes all tracked state.
module hazard_scoreboard #(
  parameter int REG_W              = 3,
  parameter int DEPTH              = 3,
  parameter int ALU_AVAIL          = 2,
  parameter int LOAD_AVAIL         = 3,
  parameter int FLUSH_DEPTH        = 0,
  parameter int ZERO_REG_HARDWIRED = 0,
  localparam int SEL_W             = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             stall,
  output logic             issue,
  output logic [SEL_W-1:0] fwd_rs_sel,
  output logic [SEL_W-1:0] fwd_rt_sel,
  output logic [SEL_W-1:0] inflight
);

  localparam bit ZERO_HW = (ZERO_REG_HARDWIRED != 0);

  // Entry 1 is the instruction in EX, entry DEPTH the one in writeback.
  logic [DEPTH:1]   ent_vld;
  logic [DEPTH:1]   ent_wr;
  logic [DEPTH:1]   ent_ld;
  logic [REG_W-1:0] ent_rd [1:DEPTH];

  logic [DEPTH:1]   rs_hit;
  logic [DEPTH:1]   rt_hit;
  logic             rs_haz;
  logic             rt_haz;
  logic [SEL_W-1:0] rs_sel_c;
  logic [SEL_W-1:0] rt_sel_c;
  logic             hazard;
  logic [SEL_W-1:0] inflight_nxt;

  // Youngest match decides: a result not yet available stalls, otherwise forward
  // from the output register of the stage after it. A writeback-stage match reads
  // the write-through register file, so it needs neither a stall nor a bypass.
  function automatic logic [SEL_W:0] resolve(input logic [DEPTH:1] hit,
                                             input logic [DEPTH:1] ld);
    int   idx;
    int   avail;
    logic haz;
    logic [SEL_W-1:0] sel;
    idx = 0;
    haz = 1'b0;
    sel = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      if (hit[i]) idx = i;
    end
    if (idx != 0 && idx < DEPTH) begin
      avail = ld[idx] ? LOAD_AVAIL : ALU_AVAIL;
      if (idx + 1 < avail) haz = 1'b1;
      else                 sel = SEL_W'(idx + 1);
    end
    return {haz, sel};
  endfunction

  // Per-entry source matches against the decoding instruction.
  always_comb begin
    rs_hit = '0;
    rt_hit = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      rs_hit[i] = id_rs_used & ent_vld[i] & ent_wr[i] & (ent_rd[i] == id_rs)
                  & ~(ZERO_HW & (id_rs == '0));
      rt_hit[i] = id_rt_used & ent_vld[i] & ent_wr[i] & (ent_rd[i] == id_rt)
                  & ~(ZERO_HW & (id_rt == '0));
    end
  end

  assign {rs_haz, rs_sel_c} = resolve(rs_hit, ent_ld);
  assign {rt_haz, rt_sel_c} = resolve(rt_hit, ent_ld);

  assign hazard = id_valid & (rs_haz | rt_haz) & ~flush;
  assign issue  = id_valid & ~hazard & ~ext_stall & ~flush;
  assign stall  = hazard | ext_stall;

  // Occupancy after this edge: +1 on issue, -1 for the retiring entry and each flush kill.
  always_comb begin
    int n;
    n = int'(inflight) + int'(issue) - int'(ent_vld[DEPTH]);
    for (int i = 2; i <= DEPTH; i++) begin
      if (flush && (i <= FLUSH_DEPTH) && ent_vld[i-1]) n = n - 1;
    end
    inflight_nxt = SEL_W'(n);
  end

  // Shift the scoreboard; entry 1 takes the issuing instruction or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld    <= '0;
      ent_wr     <= '0;
      ent_ld     <= '0;
      for (int i = 1; i <= DEPTH; i++) ent_rd[i] <= '0;
      fwd_rs_sel <= '0;
      fwd_rt_sel <= '0;
      inflight   <= '0;
    end else if (!ext_stall) begin
      for (int i = DEPTH; i >= 2; i--) begin
        ent_vld[i] <= ent_vld[i-1] & ~(flush & (i <= FLUSH_DEPTH));
        ent_wr[i]  <= ent_wr[i-1];
        ent_ld[i]  <= ent_ld[i-1];
        ent_rd[i]  <= ent_rd[i-1];
      end
      ent_vld[1] <= issue;
      ent_wr[1]  <= id_wr_en;
      ent_ld[1]  <= id_is_load;
      ent_rd[1]  <= id_rd;
      fwd_rs_sel <= issue ? rs_sel_c : '0;
      fwd_rt_sel <= issue ? rt_sel_c : '0;
      inflight   <= inflight_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: directed checks of hazard_scoreboard in three parameterisations sharing one stimulus stream.
// Latency: expectations are tagged with the cycle they apply to and compared on the falling edge.
// Backpressure: not applicable; the bench drives decode every cycle.
module tb_hazard_scoreboard;

  localparam int NU = 3;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic       flush, ext_stall;

  logic       stall_u  [NU];
  logic       issue_u  [NU];
  logic [1:0] rs_sel_u [NU];
  logic [1:0] rt_sel_u [NU];
  logic [1:0] infl_u   [NU];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit started = 0;

  typedef struct {
    int    cyc;
    int    unit;
    string name;
    int    st;
    int    is;
    int    rs;
    int    rt;
    int    inf;
  } exp_t;
  exp_t q[$];

  // u0: defaults; u1: FLUSH_DEPTH=1; u2: zero register hardwired, FLUSH_DEPTH=2
  hazard_scoreboard u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall), .stall(stall_u[0]),
    .issue(issue_u[0]), .fwd_rs_sel(rs_sel_u[0]), .fwd_rt_sel(rt_sel_u[0]), .inflight(infl_u[0]));

  hazard_scoreboard #(.FLUSH_DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall), .stall(stall_u[1]),
    .issue(issue_u[1]), .fwd_rs_sel(rs_sel_u[1]), .fwd_rt_sel(rt_sel_u[1]), .inflight(infl_u[1]));

  hazard_scoreboard #(.FLUSH_DEPTH(2), .ZERO_REG_HARDWIRED(1)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .flush(flush), .ext_stall(ext_stall), .stall(stall_u[2]),
    .issue(issue_u[2]), .fwd_rs_sel(rs_sel_u[2]), .fwd_rt_sel(rt_sel_u[2]), .inflight(infl_u[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int unit, input int act, input int req);
    if (req < 0) return;
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s u%0d: got %0d, expected %0d (cycle %0d)", nm, unit, act, req, cyc);
    end
  endtask

  // Monitor: pop every expectation due this cycle, then check the occupancy invariant.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk({e.name, ".stall"},    e.unit, int'(stall_u[e.unit]),  e.st);
      chk({e.name, ".issue"},    e.unit, int'(issue_u[e.unit]),  e.is);
      chk({e.name, ".rs_sel"},   e.unit, int'(rs_sel_u[e.unit]), e.rs);
      chk({e.name, ".rt_sel"},   e.unit, int'(rt_sel_u[e.unit]), e.rt);
      chk({e.name, ".inflight"}, e.unit, int'(infl_u[e.unit]),   e.inf);
    end
    if (started) begin
      chk("popcount0", 0, int'(infl_u[0]), $countones(u0.ent_vld));
      chk("popcount1", 1, int'(infl_u[1]), $countones(u1.ent_vld));
      chk("popcount2", 2, int'(infl_u[2]), $countones(u2.ent_vld));
    end
  end

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                       input logic wr, input logic ld, input logic fl, input logic xs);
    id_valid = v;   id_rs = rs;   id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd;     id_wr_en = wr; id_is_load = ld; flush = fl; ext_stall = xs;
  endtask

  task automatic nop();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp1(input int unit, input string nm, input int st, input int is,
                      input int rs, input int rt, input int inf);
    exp_t e;
    e.cyc = cyc; e.unit = unit; e.name = nm;
    e.st = st; e.is = is; e.rs = rs; e.rt = rt; e.inf = inf;
    q.push_back(e);
  endtask

  task automatic exp_all(input string nm, input int st, input int is,
                         input int rs, input int rt, input int inf);
    for (int u = 0; u < NU; u++) exp1(u, nm, st, is, rs, rt, inf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) begin
      nop();
      tick();
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    nop();
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;
    nop();
    exp_all("reset", 0, 0, 0, 0, 0);
    tick();

    // ALU producer then immediate consumer: forward from stage 2
    drive(1, 3'd1, 0, 3'd0, 0, 3'd3, 1, 0, 0, 0); exp_all("alu_prod", 0, 1, 0, 0, 0); tick();
    drive(1, 3'd3, 1, 3'd0, 0, 3'd4, 1, 0, 0, 0); exp_all("alu_cons", 0, 1, 0, 0, 1); tick();
    nop(); exp_all("alu_fwd", 0, 0, 2, 0, 2); tick();
    nop(); exp_all("alu_after", 0, 0, 0, 0, 2); tick();
    drain();
    nop(); exp_all("alu_drained", 0, 0, 0, 0, 0); tick();

    // Load-use: one bubble, then forward from stage 3
    drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0); exp_all("ld_prod", 0, 1, 0, 0, 0); tick();
    drive(1, 3'd0, 0, 3'd2, 1, 3'd5, 1, 0, 0, 0); exp_all("ld_stall", 1, 0, 0, 0, 1); tick();
    drive(1, 3'd0, 0, 3'd2, 1, 3'd5, 1, 0, 0, 0); exp_all("ld_issue", 0, 1, 0, 0, 1); tick();
    nop(); exp_all("ld_fwd", 0, 0, 0, 3, 2); tick();
    nop(); exp_all("ld_after", 0, 0, 0, 0, 1); tick();
    drain();

    // Two writers of r1: youngest wins; later only the writeback entry matches
    drive(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0, 0, 0); exp_all("yw_a", 0, 1, 0, 0, 0); tick();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0, 0, 0); exp_all("yw_b", 0, 1, 0, 0, 1); tick();
    drive(1, 3'd1, 1, 3'd0, 0, 3'd6, 0, 0, 0, 0); exp_all("yw_cons", 0, 1, 0, 0, 2); tick();
    nop(); exp_all("yw_fwd", 0, 0, 2, 0, 3); tick();
    drive(1, 3'd1, 1, 3'd0, 0, 3'd7, 0, 0, 0, 0); exp_all("wb_cons", 0, 1, 0, 0, 2); tick();
    nop(); exp_all("wb_sel", 0, 0, 0, 0, 2); tick();
    drain();

    // ext_stall over a pending load-use hazard, then release
    drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0); exp_all("xs_ld", 0, 1, 0, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 3'd0, 0, 3'd2, 1, 3'd5, 1, 0, 0, 1); exp_all("xs_frozen", 1, 0, 0, 0, 1); tick();
    end
    drive(1, 3'd0, 0, 3'd2, 1, 3'd5, 1, 0, 0, 0); exp_all("xs_bubble", 1, 0, 0, 0, 1); tick();
    drive(1, 3'd0, 0, 3'd2, 1, 3'd5, 1, 0, 0, 0); exp_all("xs_issue", 0, 1, 0, 0, 1); tick();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1); exp_all("xs_hold_sel", 1, 0, 0, 3, 2); tick();
    nop(); exp_all("xs_held", 0, 0, 0, 3, 2); tick();
    nop(); exp_all("xs_after", 0, 0, 0, 0, 1); tick();
    drain();

    // Flush with three valid entries, then reset mid-stream
    drive(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0, 0, 0); exp_all("fl_w1", 0, 1, 0, 0, 0); tick();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 0, 0, 0); exp_all("fl_w2", 0, 1, 0, 0, 1); tick();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 0, 0); exp_all("fl_w3", 0, 1, 0, 0, 2); tick();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 1, 0); exp_all("fl_pulse", 0, 0, 0, 0, 3); tick();
    drive(1, 3'd3, 1, 3'd0, 0, 3'd6, 1, 0, 0, 0);
    exp1(0, "fl_next", 0, 1, 0, 0, 2);
    exp1(1, "fl_next", 0, 1, 0, 0, 2);
    exp1(2, "fl_next", 0, 1, 0, 0, 1);
    tick();
    rst = 1'b1;
    drive(1, 3'd6, 1, 3'd0, 0, 3'd7, 1, 0, 0, 0);
    exp1(0, "rst_pre", -1, -1, 3, 0, 2);
    exp1(1, "rst_pre", -1, -1, 3, 0, 2);
    exp1(2, "rst_pre", -1, -1, 0, 0, 1);
    tick();
    rst = 1'b0;
    nop(); exp_all("rst_post", 0, 0, 0, 0, 0); tick();

    // Producer of r0: hardwired zero register suppresses the match
    drive(1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0, 0); exp_all("z_prod", 0, 1, 0, 0, 0); tick();
    drive(1, 3'd0, 1, 3'd0, 0, 3'd7, 0, 0, 0, 0); exp_all("z_cons", 0, 1, 0, 0, 1); tick();
    nop();
    exp1(0, "z_sel", 0, 0, 2, 0, 2);
    exp1(1, "z_sel", 0, 0, 2, 0, 2);
    exp1(2, "z_sel", 0, 0, 0, 0, 2);
    tick();
    drain();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL pending: %0d expectations left, expected 0", q.size());
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
